ycfsm_row_sync: RTL

//  Clocked, N-channel successor of the Morphle Logic yellow-cell FSM. Each channel

---
 rtl/ycfsm_row_sync.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ycfsm_row_sync.sv
// ycfsm_row_sync: clocked N-channel yellow-cell row stage.
// Each channel runs a BLOCK/EMPTY/HALF/FULL return-to-empty FSM on ternary
// in/match pairs (Vempty=00, V0=01, V1=10, 11 illegal) and drives a ternary out.
// The row adds completion detection (done), a saturating completion counter
// and sticky per-channel error flags.
// Handshake: there is no valid/ready pair. A channel value is "valid" whenever
// it is V0 or V1. A channel only accepts a new operand set after both inputs
// have returned to Vempty, which is what BLOCK enforces after reset.
// dbg_state exposes each channel FSM at [2i+1:2i]: 0 BLOCK, 1 EMPTY, 2 HALF, 3 FULL.
module ycfsm_row_sync #(
  parameter int N    = 8,
  parameter int CW   = 8,
  parameter int MODE = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [2*N-1:0] in,
  input  logic [2*N-1:0] match,
  output logic [2*N-1:0] out,
  output logic           done,
  output logic [CW-1:0]  count,
  output logic [N-1:0]   err,
  output logic [2*N-1:0] dbg_state
);

  localparam logic [1:0] VE = 2'b00;
  localparam logic [1:0] V0 = 2'b01;
  localparam logic [1:0] V1 = 2'b10;
  localparam logic [1:0] VX = 2'b11;

  typedef enum logic [1:0] {
    BLOCK = 2'd0,
    EMPTY = 2'd1,
    HALF  = 2'd2,
    FULL  = 2'd3
  } st_t;

  // Result of a complete operand pair; operands are never the illegal code.
  function automatic logic [1:0] result(input logic [1:0] a, input logic [1:0] b);
    if (MODE == 0) return (a == b) ? V1 : V0;
    else           return (b == V1) ? a : V0;
  endfunction

  logic [N-1:0] full_v;

  for (genvar g = 0; g < N; g++) begin : g_ch
    st_t        st;
    logic [1:0] li, lm;     // latched operands (Vempty when not latched)
    logic [1:0] pi, pm;     // last effective sampled inputs
    logic [1:0] o;
    logic       e;
    logic [1:0] ri, rm, ei, em;
    logic       ill_i, ill_m, viol_i, viol_m, latched;

    assign ri    = in[2*g +: 2];
    assign rm    = match[2*g +: 2];
    assign ill_i = (ri == VX);
    assign ill_m = (rm == VX);
    // An illegal code is treated as if the input had not changed.
    assign ei    = ill_i ? pi : ri;
    assign em    = ill_m ? pm : rm;

    // A latched operand flipping V0<->V1 without visiting Vempty is a violation.
    assign latched = (st == HALF) || (st == FULL);
    assign viol_i  = latched && (li != VE) && (pi != VE) && (ei != VE) && (ei != pi);
    assign viol_m  = latched && (lm != VE) && (pm != VE) && (em != VE) && (em != pm);

    // Channel FSM, operand latches, registered out and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st <= BLOCK;
        li <= VE;
        lm <= VE;
        pi <= VE;
        pm <= VE;
        o  <= VE;
        e  <= 1'b0;
      end else begin
        pi <= ei;
        pm <= em;
        if (ill_i || ill_m || viol_i || viol_m) e <= 1'b1;
        case (st)
          BLOCK: begin
            if (ei == VE && em == VE) st <= EMPTY;
          end
          EMPTY: begin
            li <= ei;
            lm <= em;
            if (ei != VE && em != VE) begin
              st <= FULL;
              o  <= result(ei, em);
            end else if (ei != VE || em != VE) begin
              st <= HALF;
            end
          end
          HALF: begin
            if (li != VE) begin
              if (ei == VE) begin
                li <= VE;
                lm <= em;
                st <= (em != VE) ? HALF : EMPTY;
              end else if (em != VE) begin
                lm <= em;
                st <= FULL;
                o  <= result(li, em);
              end
            end else begin
              if (em == VE) begin
                lm <= VE;
                li <= ei;
                st <= (ei != VE) ? HALF : EMPTY;
              end else if (ei != VE) begin
                li <= ei;
                st <= FULL;
                o  <= result(ei, lm);
              end
            end
          end
          FULL: begin
            if (ei == VE && em == VE) begin
              st <= EMPTY;
              li <= VE;
              lm <= VE;
              o  <= VE;
            end
          end
          default: st <= BLOCK;
        endcase
      end
    end

    assign out[2*g +: 2]       = o;
    assign err[g]              = e;
    assign full_v[g]           = (st == FULL);
    assign dbg_state[2*g +: 2] = st;
  end

  // Row completion flag and saturating count of its rising edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done  <= 1'b0;
      count <= '0;
    end else begin
      done <= &full_v;
      if ((&full_v) && !done && (count != {CW{1'b1}})) count <= count + 1'b1;
    end
  end

endmodule
